// File: rtl/program_loader.sv
// Streams a counted, checksummed byte image into instruction memory and holds the core in reset until it verifies.
// Write latency: one cycle after the B0 byte is accepted. Accepts one byte per cycle, with one WRITE bubble per word.
module program_loader #(
  parameter logic [11:0] BASE_ADDR = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        im_we,
  output logic [11:0] im_addr,
  output logic [18:0] im_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_B2, S_B1, S_B0, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt_hi;
  logic [11:0] count;
  logic [11:0] index;
  logic [11:0] index_nxt;
  logic [7:0]  chk;
  logic [2:0]  b2;
  logic [7:0]  b1;
  logic        xfer;

  assign byte_ready = (state == S_CNT_HI) || (state == S_CNT_LO) || (state == S_B2) ||
                      (state == S_B1) || (state == S_B0) || (state == S_CHK);
  assign im_we      = (state == S_WRITE);
  assign cpu_hold   = (state != S_DONE);
  assign done       = (state == S_DONE);
  assign err        = (state == S_ERR);
  assign xfer       = byte_valid && byte_ready;
  assign index_nxt  = index + 12'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_CNT_HI;
      S_CNT_HI: if (xfer) state_nxt = (byte_data[7:4] != 4'd0) ? S_ERR : S_CNT_LO;
      S_CNT_LO: if (xfer) state_nxt = ({cnt_hi, byte_data} == 12'd0) ? S_CHK : S_B2;
      S_B2:     if (xfer) state_nxt = (byte_data[7:3] != 5'd0) ? S_ERR : S_B1;
      S_B1:     if (xfer) state_nxt = S_B0;
      S_B0:     if (xfer) state_nxt = S_WRITE;
      S_WRITE:  state_nxt = (index_nxt == count) ? S_CHK : S_B2;
      S_CHK:    if (xfer) state_nxt = (byte_data == chk) ? S_DONE : S_ERR;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Address and word are captured with the B0 byte so they are stable throughout WRITE and hold afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_hi   <= 4'd0;
      count    <= 12'd0;
      index    <= 12'd0;
      chk      <= 8'd0;
      b2       <= 3'd0;
      b1       <= 8'd0;
      im_addr  <= 12'd0;
      im_wdata <= 19'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            index <= 12'd0;
            chk   <= 8'd0;
          end
        end
        S_CNT_HI: if (xfer) cnt_hi <= byte_data[3:0];
        S_CNT_LO: if (xfer) count <= {cnt_hi, byte_data};
        S_B2: begin
          if (xfer) begin
            b2  <= byte_data[2:0];
            chk <= chk ^ byte_data;
          end
        end
        S_B1: begin
          if (xfer) begin
            b1  <= byte_data;
            chk <= chk ^ byte_data;
          end
        end
        S_B0: begin
          if (xfer) begin
            im_addr  <= BASE_ADDR + index;
            im_wdata <= {b2, b1, byte_data};
            chk      <= chk ^ byte_data;
          end
        end
        S_WRITE: index <= index_nxt;
        default: ;
      endcase
    end
  end

endmodule
